// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state encoding and instruction field helpers shared by
// multicycle_cpu_core and cpu_alu.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [2:0] instr_rd(input logic [INSTR_W-1:0] ir);
        return ir[11:9];
    endfunction

    function automatic logic [2:0] instr_rs1(input logic [INSTR_W-1:0] ir);
        return ir[8:6];
    endfunction

    function automatic logic [2:0] instr_rs2(input logic [INSTR_W-1:0] ir);
        return ir[5:3];
    endfunction

    function automatic logic [7:0] instr_imm8(input logic [INSTR_W-1:0] ir);
        return ir[7:0];
    endfunction

    // Ops 0..4 go through the ALU and are the only ones that update flags.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for the multi-cycle core. Carry is the ADD
// carry-out or the SUB borrow; logic ops report carry 0.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum     = '0;
        res_o   = '0;
        carry_o = 1'b0;
        case (op_i)
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_ADD: begin
                sum     = {1'b0, a_i} + {1'b0, b_i};
                res_o   = sum[DATA_W-1:0];
                carry_o = sum[DATA_W];
            end
            OP_SUB: begin
                res_o   = a_i - b_i;
                carry_o = (a_i < b_i);
            end
            OP_XOR: res_o = a_i ^ b_i;
            default: begin
                res_o   = '0;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: multi-cycle CPU with req/ack instruction and data ports.
// Define CPU_RETIRE_CNT_EN to add the retired_cnt completed-instruction counter.
module multicycle_cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              negative,
    output logic              halted
`ifdef CPU_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired_cnt
`endif
);

    // state  | meaning
    // FETCH  | imem_req high until imem_ack; latch instruction, pc+1
    // DECODE | read rs1/rs2/rd operands from the register file
    // EXEC   | ALU/LDI compute + flags, branch/jump resolve, launch data access
    // MEM    | dmem_req high until dmem_ack
    // WB     | register write (R0 discarded) and result update
    // HALT   | terminal, no requests until reset

    localparam int REG_AW = $clog2(NUM_REGS);

    state_e            state_q;
    logic [15:0]       ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] opd_q;
    logic [DATA_W-1:0] wb_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              carry_q;
    logic              neg_q;
    logic              halted_q;
    logic              imem_req_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [DATA_W-1:0] dmem_wdata_q;

    logic [3:0]        op;
    logic [2:0]        rd_f;
    logic [2:0]        rs1_f;
    logic [2:0]        rs2_f;
    logic [7:0]        imm8;
    logic [REG_AW-1:0] rd_idx;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] rd_val;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] imm_data;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    assign op       = instr_op(ir_q);
    assign rd_f     = instr_rd(ir_q);
    assign rs1_f    = instr_rs1(ir_q);
    assign rs2_f    = instr_rs2(ir_q);
    assign imm8     = instr_imm8(ir_q);
    assign rd_idx   = rd_f[REG_AW-1:0];
    assign rs1_idx  = rs1_f[REG_AW-1:0];
    assign rs2_idx  = rs2_f[REG_AW-1:0];

    assign rs1_val  = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    assign rs2_val  = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
    assign rd_val   = (rd_idx == '0) ? '0 : rf_q[rd_idx];

    assign pc_inc_d = pc_q + ADDR_W'(1);
    assign imm_addr = ADDR_W'(imm8);
    assign imm_data = DATA_W'(imm8);

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i    (op),
        .a_i     (opa_q),
        .b_i     (opb_q),
        .res_o   (alu_res),
        .carry_o (alu_carry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            ir_q         <= '0;
            pc_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            opd_q        <= '0;
            wb_q         <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            neg_q        <= 1'b0;
            halted_q     <= 1'b0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    // An ack only counts once our own request is visible, so a
                    // stale ack in the first cycle after reset is dropped.
                    if (imem_req_q && imem_ack) begin
                        ir_q       <= imem_rdata;
                        pc_q       <= pc_inc_d;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end

                DECODE: begin
                    opa_q   <= rs1_val;
                    opb_q   <= rs2_val;
                    opd_q   <= rd_val;
                    state_q <= EXEC;
                end

                EXEC: begin
                    if (is_alu_op(op)) begin
                        wb_q    <= alu_res;
                        zero_q  <= (alu_res == '0);
                        neg_q   <= alu_res[DATA_W-1];
                        carry_q <= alu_carry;
                        state_q <= WB;
                    end else begin
                        case (op)
                            OP_LDI: begin
                                wb_q    <= imm_data;
                                state_q <= WB;
                            end
                            OP_LD, OP_ST: begin
                                dmem_req_q   <= 1'b1;
                                dmem_we_q    <= (op == OP_ST);
                                dmem_addr_q  <= ADDR_W'(opa_q);
                                dmem_wdata_q <= opb_q;
                                state_q      <= MEM;
                            end
                            OP_BEQZ: begin
                                if (opd_q == '0) begin
                                    pc_q <= imm_addr;
                                end
                                imem_req_q <= 1'b1;
                                state_q    <= FETCH;
                            end
                            OP_JMP: begin
                                pc_q       <= imm_addr;
                                imem_req_q <= 1'b1;
                                state_q    <= FETCH;
                            end
                            OP_HALT: begin
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end
                            default: begin
                                imem_req_q <= 1'b1;
                                state_q    <= FETCH;
                            end
                        endcase
                    end
                end

                MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        if (dmem_we_q) begin
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end else begin
                            wb_q    <= dmem_rdata;
                            state_q <= WB;
                        end
                    end
                end

                WB: begin
                    if (rd_idx != '0) begin
                        rf_q[rd_idx] <= wb_q;
                    end
                    result_q   <= wb_q;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end

                HALT: begin
                    state_q <= HALT;
                end

                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= FETCH;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign carry      = carry_q;
    assign negative   = neg_q;
    assign halted     = halted_q;

`ifdef CPU_RETIRE_CNT_EN
    logic        retire;
    logic [31:0] retired_q;

    // Completion points: WB, store ack, and any EXEC that does not continue
    // to WB or MEM (branches, jumps, NOPs and HALT).
    always_comb begin
        retire = 1'b0;
        case (state_q)
            WB:      retire = 1'b1;
            MEM:     retire = dmem_ack && dmem_we_q;
            EXEC:    retire = !(is_alu_op(op) || (op == OP_LDI) ||
                                (op == OP_LD) || (op == OP_ST));
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb_multicycle_cpu_core: directed programs against an instruction-level model
// of the CPU, checked at every fetch, data access and halted cycle.
module tb_multicycle_cpu_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [7:0]  dmem_rdata = 8'h0;
    logic [7:0]  pc;
    logic [7:0]  result;
    logic        zero;
    logic        carry;
    logic        negative;
    logic        halted;
`ifdef CPU_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_cpu_core dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .negative   (negative),
        .halted     (halted)
`ifdef CPU_RETIRE_CNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    logic [15:0] imem   [256];
    logic [7:0]  dmem_b [256];

    logic [7:0]  m_rf  [8];
    logic [7:0]  m_mem [256];
    logic [7:0]  m_pc;
    logic [7:0]  m_result;
    logic        m_z, m_c, m_n, m_halted;
    int          m_retired;

    int          checks = 0;
    int          errors = 0;
    int          dmem_delay = 0;
    int          dwait = 0;
    int          d_hold = 0;
    int          lat_exp = 0;
    int          last_lat = 0;
    int          cyc_since = 0;
    int          zero_fetches = 0;
    bit          first_fetch = 1'b1;
    bit          imem_stall = 1'b0;
    bit          exp_d_valid = 1'b0;
    logic        exp_d_we;
    logic [7:0]  exp_d_addr;
    logic [7:0]  exp_d_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input int rd, input int rs1, input int rs2);
        logic [2:0] a, b, c;
        a = rd[2:0];
        b = rs1[2:0];
        c = rs2[2:0];
        return {op, a, b, c, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input int rd, input logic [7:0] imm);
        logic [2:0] a;
        a = rd[2:0];
        return {op, a, 1'b0, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = dmem_b[i];
        m_pc = 8'h00; m_result = 8'h00;
        m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_halted = 1'b0;
        m_retired = 0;
        first_fetch = 1'b1;
        cyc_since = 0;
        exp_d_valid = 1'b0;
        zero_fetches = 0;
    endtask

    // Architectural effect of one instruction plus its expected cycle count.
    task automatic model_exec(input logic [15:0] ins);
        logic [3:0] op;
        int rd, rs1, rs2;
        logic [7:0] imm, a, b, d, r;
        logic [8:0] s;
        bit wr, alu;
        op = ins[15:12]; rd = int'(ins[11:9]); rs1 = int'(ins[8:6]); rs2 = int'(ins[5:3]);
        imm = ins[7:0];
        a = m_rf[rs1]; b = m_rf[rs2]; d = m_rf[rd];
        m_pc = m_pc + 8'd1;
        r = 8'h00; wr = 1'b0; alu = 1'b0; lat_exp = 3;
        case (op)
            4'h0: begin r = a & b; m_c = 1'b0; alu = 1'b1; end
            4'h1: begin r = a | b; m_c = 1'b0; alu = 1'b1; end
            4'h2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; m_c = s[8]; alu = 1'b1; end
            4'h3: begin r = a - b; m_c = (a < b); alu = 1'b1; end
            4'h4: begin r = a ^ b; m_c = 1'b0; alu = 1'b1; end
            4'h5: begin r = imm; wr = 1'b1; lat_exp = 4; end
            4'h6: begin
                r = m_mem[a]; wr = 1'b1; lat_exp = 5 + dmem_delay;
                exp_d_valid = 1'b1; exp_d_we = 1'b0; exp_d_addr = a; exp_d_wdata = b;
            end
            4'h7: begin
                m_mem[a] = b; lat_exp = 4 + dmem_delay;
                exp_d_valid = 1'b1; exp_d_we = 1'b1; exp_d_addr = a; exp_d_wdata = b;
            end
            4'h8: if (d == 8'h00) m_pc = imm;
            4'h9: m_pc = imm;
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
        if (alu) begin
            m_z = (r == 8'h00); m_n = r[7]; wr = 1'b1; lat_exp = 4;
        end
        if (wr) begin
            if (rd != 0) m_rf[rd] = r;
            m_result = r;
        end
        m_retired++;
    endtask

    task automatic step();
        @(negedge clk);
        cyc_since++;
        if (dmem_req) begin
            d_hold++;
            chk("dmem_req_expected", {31'd0, dmem_req}, {31'd0, exp_d_valid});
            chk("dmem_addr", {24'd0, dmem_addr}, {24'd0, exp_d_addr});
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_d_we});
            if (exp_d_we) chk("dmem_wdata", {24'd0, dmem_wdata}, {24'd0, exp_d_wdata});
            if (dwait >= dmem_delay) begin
                dmem_ack = 1'b1;
                if (dmem_we) dmem_b[dmem_addr] = dmem_wdata;
                else dmem_rdata = dmem_b[dmem_addr];
                exp_d_valid = 1'b0;
            end else begin
                dmem_ack = 1'b0;
                dwait++;
            end
        end else begin
            if (d_hold > 0) chk("dmem_req_hold_cycles", d_hold, dmem_delay + 1);
            d_hold = 0;
            dmem_ack = 1'b0;
            dwait = 0;
        end

        if (imem_req && !imem_stall) begin
            if (m_halted) begin
                checks++; errors++;
                $display("FAIL fetch_after_halt: got imem_req=1 at 0x%0h, expected 0", imem_addr);
            end
            if (!first_fetch) chk("latency", cyc_since, lat_exp);
            last_lat = cyc_since;
            chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
            chk("pc", {24'd0, pc}, {24'd0, m_pc});
            chk("result", {24'd0, result}, {24'd0, m_result});
            chk("flags_zcn", {29'd0, zero, carry, negative}, {29'd0, m_z, m_c, m_n});
            chk("halted_running", {31'd0, halted}, 32'd0);
            if (m_pc == 8'h00) zero_fetches++;
            imem_ack = 1'b1;
            imem_rdata = imem[imem_addr];
            model_exec(imem[m_pc]);
            first_fetch = 1'b0;
            cyc_since = 0;
        end else begin
            imem_ack = 1'b0;
        end

        if (m_halted && cyc_since >= 3) begin
            chk("halted", {31'd0, halted}, 32'd1);
            chk("imem_req_halted", {31'd0, imem_req}, 32'd0);
            chk("pc_halted", {24'd0, pc}, {24'd0, m_pc});
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = 16'h0; dmem_rdata = 8'h0;
        imem_stall = 1'b0; dwait = 0; d_hold = 0;
        for (int i = 0; i < 256; i++) dmem_b[i] = 8'(i) ^ 8'h5A;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags_halt", {28'd0, zero, carry, negative, halted}, 32'd0);
        chk("rst_dmem_bus", {15'd0, dmem_we, dmem_addr, dmem_wdata}, 32'd0);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_until_halt(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            step();
            if (m_halted && cyc_since >= 25) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no halt within 600 cycles, expected halt", name);
        end
`ifdef CPU_RETIRE_CNT_EN
        chk("retired_cnt", retired_cnt, m_retired);
`endif
    endtask

    initial begin
        // T1: basic ALU / LDI
        clear_imem(); dmem_delay = 0;
        imem[0] = enc_i(4'h5, 1, 8'h05);
        imem[1] = enc_i(4'h5, 2, 8'h03);
        imem[2] = enc_r(4'h2, 3, 1, 2);
        do_reset();
        run_until_halt("t1");
        chk("t1_result", {24'd0, result}, 32'h08);
        chk("t1_flags_zcn", {29'd0, zero, carry, negative}, 32'd0);
        chk("t1_add_latency", last_lat, 4);
        chk("t1_model_r3", {24'd0, m_rf[3]}, 32'h08);

        // T2: carry out, borrow, negative, logic op clears carry
        clear_imem();
        imem[0] = enc_i(4'h5, 1, 8'hFF);
        imem[1] = enc_i(4'h5, 2, 8'h01);
        imem[2] = enc_r(4'h2, 3, 1, 2);
        imem[3] = enc_r(4'h3, 4, 2, 1);
        imem[4] = enc_r(4'h4, 5, 1, 2);
        do_reset();
        run_until_halt("t2");
        chk("t2_model_r3", {24'd0, m_rf[3]}, 32'h00);
        chk("t2_model_r4", {24'd0, m_rf[4]}, 32'h02);
        chk("t2_result", {24'd0, result}, 32'hFE);
        chk("t2_flags_zcn", {29'd0, zero, carry, negative}, 32'b001);

        // T3: store then load with a 3-cycle data ack delay
        clear_imem(); dmem_delay = 3;
        imem[0] = enc_i(4'h5, 1, 8'h20);
        imem[1] = enc_i(4'h5, 2, 8'h01);
        imem[2] = enc_r(4'h7, 0, 1, 2);
        imem[3] = enc_r(4'h6, 5, 1, 0);
        do_reset();
        run_until_halt("t3");
        chk("t3_ld_latency", last_lat, 8);
        chk("t3_result", {24'd0, result}, 32'h01);
        chk("t3_mem_0x20", {24'd0, dmem_b[8'h20]}, 32'h01);
        chk("t3_model_r5", {24'd0, m_rf[5]}, 32'h01);
        dmem_delay = 0;

        // T4: R0 discard, untaken and taken BEQZ
        clear_imem();
        imem[0] = enc_i(4'h5, 0, 8'h07);
        imem[1] = enc_r(4'h2, 1, 0, 0);
        imem[2] = enc_i(4'h5, 3, 8'h01);
        imem[3] = enc_i(4'h8, 3, 8'h40);
        imem[4] = enc_i(4'h8, 0, 8'h10);
        imem[5] = enc_i(4'h5, 7, 8'hEE);
        do_reset();
        run_until_halt("t4");
        chk("t4_pc", {24'd0, pc}, 32'h11);
        chk("t4_result", {24'd0, result}, 32'h01);
        chk("t4_zero", {31'd0, zero}, 32'd1);
        chk("t4_model_r1", {24'd0, m_rf[1]}, 32'h00);

        // T5: JMP 0xFF, NOP at 0xFF, pc wraps to 0
        clear_imem();
        imem[8'h00] = enc_i(4'h8, 4, 8'h10);
        imem[8'h10] = enc_i(4'h5, 4, 8'h01);
        imem[8'h11] = enc_i(4'h9, 0, 8'hFF);
        imem[8'hFF] = 16'hA000;
        do_reset();
        run_until_halt("t5");
        chk("t5_fetches_at_0", zero_fetches, 2);
        chk("t5_pc", {24'd0, pc}, 32'h02);
        chk("t5_result", {24'd0, result}, 32'h01);

        // T6: reset while a fetch is pending, stale ack after release
        clear_imem();
        imem[0] = enc_i(4'h5, 1, 8'h05);
        imem[1] = enc_i(4'h5, 2, 8'h03);
        imem[2] = enc_r(4'h2, 3, 1, 2);
        do_reset();
        imem_stall = 1'b1;
        repeat (3) step();
        chk("t6_req_pending", {31'd0, imem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("t6_req_drop_async", {31'd0, imem_req}, 32'd0);
        chk("t6_pc_reset", {24'd0, pc}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 16'hF000;
        @(negedge clk);
        imem_ack = 1'b0;
        model_reset();
        imem_stall = 1'b0;
        run_until_halt("t6");
        chk("t6_result", {24'd0, result}, 32'h08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
